// File: rtl/commit_alloc_ctrl_pkg.sv
// Shared rename-stage definitions: commit-station sizing, recovery FSM
// states and the vector-fetch reservation size.
package commit_alloc_ctrl_pkg;

   localparam int NCOMMIT_DEF  = 32;
   localparam int LNCOMMIT_DEF = 5;
   localparam int NDEC_DEF     = 4;

   // Stations claimed by one vector-fetch micro-sequence
   localparam int VF_RESERVE = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      RECOVER1 = 2'd1,
      RECOVER2 = 2'd2
   } commit_state_e;

endpackage

// File: rtl/commit_alloc_ctrl_ptr_math.sv
// Modulo-NCOMMIT pointer arithmetic: a+b (pointer advance) or a-b
// (ring distance), selected by sub_i.
module commit_ptr_math
   import commit_alloc_ctrl_pkg::*;
#(
   parameter int LNCOMMIT = LNCOMMIT_DEF
) (
   input  logic [LNCOMMIT-1:0] a_i,
   input  logic [LNCOMMIT:0]   b_i,
   input  logic                sub_i,
   output logic [LNCOMMIT-1:0] res_o
);

   logic [LNCOMMIT:0] a_ext;

   assign a_ext = {1'b0, a_i};
   // Dropping the carry/borrow bit gives the ring wrap for a power-of-2 size
   assign res_o = LNCOMMIT'(sub_i ? (a_ext - b_i) : (a_ext + b_i));

endmodule

// File: rtl/commit_alloc_ctrl.sv
// Commit-station allocator: head/tail/occupancy tracking with flush,
// trap and vector-fetch recovery bubbles.
module commit_alloc_ctrl
   import commit_alloc_ctrl_pkg::*;
#(
   parameter int NCOMMIT  = NCOMMIT_DEF,
   parameter int LNCOMMIT = LNCOMMIT_DEF,
   parameter int NDEC     = NDEC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          alloc_count,
   input  logic [3:0]          commit_count,
   input  logic                br_flush,
   input  logic [LNCOMMIT-1:0] flush_addr,
   input  logic                trap_flush,
   input  logic                force_fetch,
   output logic [LNCOMMIT-1:0] next_start,
   output logic [LNCOMMIT-1:0] head,
   output logic [LNCOMMIT:0]   current_available,
   output logic                reloading,
   output logic                alloc_overflow
);

   localparam int OW = LNCOMMIT + 1;
   localparam logic [OW-1:0] FULL   = OW'(NCOMMIT);
   localparam logic [OW-1:0] MAXW   = OW'(2 * NDEC);
   localparam logic [OW-1:0] VF_W   = OW'(VF_RESERVE);
   localparam logic [OW-1:0] ONE_W  = OW'(1);

   commit_state_e state_q, state_d;
   logic [LNCOMMIT-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0]       occ_q, occ_d;
   logic                ovf_q, ovf_d;

   logic [OW-1:0]       commit_w, alloc_w, avail, commit_adv, alloc_acc;
   logic [OW-1:0]       flush_len, br_occ;
   logic                commit_bad, alloc_bad;
   logic [LNCOMMIT-1:0] head_adv, flush_dist, tail_sum, tail_base;
   logic [OW-1:0]       tail_inc;

   assign commit_w   = OW'(commit_count);
   assign alloc_w    = OW'(alloc_count);
   assign avail      = FULL - occ_q;

   // Over-commit is clamped so head never passes the tail
   assign commit_bad = (commit_w > occ_q) || (commit_w > MAXW);
   assign commit_adv = (commit_w > occ_q) ? occ_q : commit_w;
   assign alloc_bad  = (alloc_w > avail) || (alloc_w > MAXW);
   assign alloc_acc  = (state_q == RUN && !alloc_bad) ? alloc_w : '0;

   assign flush_len  = {1'b0, flush_dist} + ONE_W;
   assign br_occ     = (flush_len > commit_adv) ? (flush_len - commit_adv) : '0;

   commit_ptr_math #(.LNCOMMIT(LNCOMMIT)) u_head (
      .a_i(head_q), .b_i(commit_adv), .sub_i(1'b0), .res_o(head_adv)
   );

   commit_ptr_math #(.LNCOMMIT(LNCOMMIT)) u_dist (
      .a_i(flush_addr), .b_i({1'b0, head_q}), .sub_i(1'b1), .res_o(flush_dist)
   );

   commit_ptr_math #(.LNCOMMIT(LNCOMMIT)) u_tail (
      .a_i(tail_base), .b_i(tail_inc), .sub_i(1'b0), .res_o(tail_sum)
   );

   always_comb begin
      state_d   = (state_q == RECOVER1) ? RECOVER2 : RUN;
      head_d    = head_adv;
      tail_base = tail_q;
      tail_inc  = alloc_acc;
      tail_d    = tail_sum;
      occ_d     = occ_q + alloc_acc - commit_adv;
      ovf_d     = ovf_q | commit_bad;

      if (force_fetch) begin
         state_d  = RECOVER1;
         tail_inc = VF_W;
         occ_d    = VF_W;
      end else if (trap_flush) begin
         state_d  = RECOVER1;
         tail_d   = head_adv;
         occ_d    = '0;
      end else if (br_flush) begin
         state_d   = RECOVER1;
         tail_base = flush_addr;
         tail_inc  = ONE_W;
         occ_d     = br_occ;
      end else if (state_q == RUN && alloc_bad) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         ovf_q   <= ovf_d;
      end
   end

   assign next_start        = tail_q;
   assign head              = head_q;
   assign current_available = avail;
   assign reloading         = (state_q != RUN);
   assign alloc_overflow    = ovf_q;

endmodule

// File: tb/tb_commit_alloc_ctrl.sv
// Directed bench for commit_alloc_ctrl with hand-computed expectations.
module tb_commit_alloc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] alloc_count, commit_count;
   logic       br_flush, trap_flush, force_fetch;
   logic [4:0] flush_addr;
   logic [4:0] next_start, head;
   logic [5:0] current_available;
   logic       reloading, alloc_overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   commit_alloc_ctrl #(.NCOMMIT(32), .LNCOMMIT(5), .NDEC(4)) dut (
      .clk(clk), .reset(reset),
      .alloc_count(alloc_count), .commit_count(commit_count),
      .br_flush(br_flush), .flush_addr(flush_addr),
      .trap_flush(trap_flush), .force_fetch(force_fetch),
      .next_start(next_start), .head(head),
      .current_available(current_available),
      .reloading(reloading), .alloc_overflow(alloc_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int h, input int t, input int av,
                          input int rl, input int ov);
      chk({tag, ".head"},  32'(head), 32'(h));
      chk({tag, ".tail"},  32'(next_start), 32'(t));
      chk({tag, ".avail"}, 32'(current_available), 32'(av));
      chk({tag, ".reload"}, 32'(reloading), 32'(rl));
      chk({tag, ".ovf"},   32'(alloc_overflow), 32'(ov));
   endtask

   task automatic idle();
      alloc_count  = 0;
      commit_count = 0;
      br_flush     = 0;
      trap_flush   = 0;
      force_fetch  = 0;
      flush_addr   = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int a, input int c);
      alloc_count  = 4'(a);
      commit_count = 4'(c);
      tick();
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      // reset must win over simultaneous activity
      alloc_count = 8;
      force_fetch = 1;
      tick();
      chk_all("reset", 0, 0, 32, 0, 0);
      reset = 1'b0;
      idle();

      // Fill the queue with four 8-wide allocations
      step(8, 0); chk("fill1.avail", 32'(current_available), 24);
      step(8, 0); chk("fill2.avail", 32'(current_available), 16);
      step(8, 0); chk("fill3.tail",  32'(next_start), 24);
      step(8, 0); chk_all("full", 0, 0, 0, 0, 0);

      // Allocation into a full queue is dropped; commit still retires 3
      step(1, 3); chk_all("ovf_alloc", 3, 0, 3, 0, 1);

      // Build head=30, tail=6, occupancy 8
      do_reset();
      chk_all("reset2", 0, 0, 32, 0, 0);
      step(8, 0); step(8, 0); step(8, 0);
      step(8, 8); step(6, 8); step(0, 8); step(0, 6);
      chk_all("pre_br", 30, 6, 24, 0, 0);

      // Mispredict with a concurrent commit; allocation must be ignored
      br_flush = 1; flush_addr = 5'd1; commit_count = 1; alloc_count = 5;
      tick(); idle();
      chk_all("br_flush", 31, 2, 29, 1, 0);
      alloc_count = 4;
      tick(); idle();
      chk_all("br_rec2", 31, 2, 29, 1, 0);
      tick();
      chk_all("br_run", 31, 2, 29, 0, 0);
      step(1, 0);
      chk("br_alloc.tail", 32'(next_start), 3);

      // Trap beats branch flush; commit applied first
      do_reset();
      step(8, 0); step(0, 5);
      chk_all("pre_trap", 5, 8, 29, 0, 0);
      trap_flush = 1; br_flush = 1; flush_addr = 5'd20; commit_count = 2;
      tick(); idle();
      chk_all("trap", 7, 7, 32, 1, 0);

      // Vector-fetch reservation, then a branch flush in RECOVER2
      do_reset();
      force_fetch = 1;
      tick(); idle();
      chk_all("vf", 0, 2, 30, 1, 0);
      tick();
      chk_all("vf_rec2", 0, 2, 30, 1, 0);
      br_flush = 1; flush_addr = 5'd1;
      tick(); idle();
      chk_all("vf_br", 0, 2, 30, 1, 0);
      commit_count = 1; alloc_count = 3;
      tick(); idle();
      chk_all("vf_commit", 1, 2, 31, 1, 0);
      tick();
      chk_all("vf_run", 1, 2, 31, 0, 0);

      // Reset while in RECOVER1
      force_fetch = 1;
      tick(); idle();
      chk("r1.reload", 32'(reloading), 1);
      do_reset();
      chk_all("rst_rec", 0, 0, 32, 0, 0);
      tick();
      chk_all("rst_rec_next", 0, 0, 32, 0, 0);

      // Over-commit on an empty queue is clamped and flagged
      step(0, 1);
      chk_all("ovf_commit", 0, 0, 32, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
